fabric_config_loader: RTL and testbench
=======================================

Name: fabric_config_loader

Overview:
- Configuration front-end that sits directly upstream of the CLB array's two scan chains (CLB chain and connection chain).
- Accepts configuration words over a valid/ready stream and serialises them, LSB first, into the CLB chain first and then the connection chain.
- Generates the scan clock and scan enables, and reports busy/done to the top level.

Parameters:
- WORD_W, 32, width of incoming configuration words.
- CLB_CHAIN_LEN, 4096, bits in the CLB scan chain (clb_scan_in to clb_scan_out of the array).
- CONN_CHAIN_LEN, 8192, bits in the connection scan chain.
- CNT_W, $clog2(max(CLB_CHAIN_LEN,CONN_CHAIN_LEN))+1, bit-counter width (derived).

Ports:
- clk  in  1  system clock; every register in this block is clocked by it.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- cfg_data  in  WORD_W  configuration word.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader can accept a word.
- scan_clk  out  1  registered scan clock to the array, idle low.
- clb_scan_en  out  1  CLB chain shift enable.
- conn_scan_en  out  1  connection chain shift enable.
- clb_scan_data  out  1  serial data into the array's CLB chain.
- conn_scan_data  out  1  serial data into the array's connection chain.
- busy  out  1  load in progress.
- done  out  1  last load completed; held until the next accepted start.
- err  out  1  CRC mismatch; present only with CFG_CRC_EN, tied 0 otherwise.

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, including scan_clk, both enables, both data outputs, cfg_ready, busy, done and err. The word buffer is emptied and the counters are cleared.
- Reset mid-load: the load is abandoned immediately. The array contents are undefined, and a new start is required.
- FSM states and transitions:
  - IDLE: on start, go to LOAD_CLB.
  - LOAD_CLB: after the CLB_CHAIN_LEN-th bit, go to LOAD_CONN.
  - LOAD_CONN: after the CONN_CHAIN_LEN-th bit, go to CHECK if CFG_CRC_EN is defined, otherwise go to DONE.
  - CHECK: after the CRC word is accepted, go to DONE.
  - DONE: on start, go to LOAD_CLB.
- start is ignored in LOAD_CLB, LOAD_CONN and CHECK.
- busy is 1 in LOAD_CLB, LOAD_CONN and CHECK.
- done is set on entry to DONE and cleared in the cycle start is accepted.
- Word buffer:
  - Single entry; cfg_ready = buffer empty && state is LOAD_CLB, LOAD_CONN or CHECK.
  - Loaded on cfg_valid && cfg_ready.
  - Emptied after its last used bit's scan_clk high phase.
- Bit timing (2 clk cycles per bit):
  - Phase 0: scan_clk = 0, the active data output updates to the next buffer bit.
  - Phase 1: scan_clk = 1, and the array captures on this rising edge.
- Stall: if the buffer is empty, scan_clk holds 0 and the active enable stays 1. No pulse is issued until a word arrives.
- Chain alignment:
  - Each chain starts on a fresh word, and the CLB chain needs ceil(CLB_CHAIN_LEN/WORD_W) words.
  - Unused upper bits of a chain's final word are discarded.
  - Bit 0 of the first word is shifted first, so it ends at the far end of the chain.
- Enables: clb_scan_en is 1 only in LOAD_CLB and conn_scan_en only in LOAD_CONN. Each drops in the clk cycle after its chain's final rising scan_clk, so the array holds its configuration.
- Inactive data outputs are held at 0.
- Accepting the first word and the start in the same cycle is impossible, because cfg_ready is 0 in IDLE.

Optional Feature:
- CFG_CRC_EN defined:
  - A CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflection) is accumulated over every accepted configuration word.
  - In CHECK, one extra word is the expected CRC. On mismatch, err is set and held until the next start or rst. done still asserts.
- CFG_CRC_EN undefined: there is no CHECK state, and err is tied 0.

Decomposition:
- Package fabric_cfg_pkg: the state enum (IDLE, LOAD_CLB, LOAD_CONN, CHECK, DONE), the default WORD_W, and the CRC polynomial and init constants.
- One sub-module: cfg_serializer. It holds the word buffer, bit index, phase toggle and scan_clk generation. Inputs are a word, a bits-to-use count and a go handshake; outputs are serial data and a word-consumed pulse.

Test Plan (CLB_CHAIN_LEN=40, CONN_CHAIN_LEN=8, WORD_W=32 unless noted):
1. start, then words 0x000000A5, 0x00000003, 0x0000003C with cfg_valid held -> exactly 40 scan_clk pulses with clb_scan_en=1, then 8 with conn_scan_en=1. CLB bits 0..39 are A5 LSB first, 24 zeros, then 3 LSB first and 6 zeros. Connection bits are 0x3C LSB first. done=1, busy=0.
2. Same load with cfg_valid deasserted for 10 cycles between words -> scan_clk low and clb_scan_en high through the gap. The final bitstream is identical to test 1.
3. rst asserted after the 20th CLB pulse -> in the next cycle every output is 0 and the FSM is in IDLE. A fresh start produces the full test 1 sequence.
4. start pulsed during LOAD_CONN -> ignored, with no pulse-count change. A second start in DONE clears done and restarts LOAD_CLB.
5. CFG_CRC_EN defined: correct CRC word -> err=0, done=1. Flipping one CRC bit -> err=1, done=1, and err clears on the next start.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Contents: load FSM state enum, default word width, CRC-32 constants and a
// single-bit CRC-32 update helper (MSB-first, no reflection).
package fabric_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_CLB  = 3'd1,
    ST_LOAD_CONN = 3'd2,
    ST_CHECK     = 3'd3,
    ST_DONE      = 3'd4
  } cfg_state_e;

  localparam int          CFG_WORD_W = 32;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Advance a non-reflected CRC-32 by one input bit.
  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic din);
    logic fb;
    fb = crc[31] ^ din;
    return {crc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Purpose: single-entry word buffer that shifts a word out LSB first with a generated scan clock.
// Latency: 2 clk per bit (low phase presents data, high phase is the capture edge); first bit 2 clk after load.
// Backpressure: word_rdy_o is high only while the buffer is empty; an empty buffer holds scan_clk low.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   word_dat_i        word to serialise; word_nbits_i = number of low bits to use (1..WORD_W)
//   word_vld_i/_rdy_o load handshake for the buffer
//   ser_dat_o         serial data (registered), scan_clk_o registered scan clock, idle low
//   word_done_o       high during the high phase of the word's last used bit
module cfg_serializer
  import fabric_cfg_pkg::*;
#(
  parameter int WORD_W = CFG_WORD_W,
  parameter int NB_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_dat_i,
  input  logic [NB_W-1:0]   word_nbits_i,
  input  logic              word_vld_i,
  output logic              word_rdy_o,
  output logic              ser_dat_o,
  output logic              scan_clk_o,
  output logic              word_done_o
);

  logic              full_q, full_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [NB_W-1:0]   rem_q, rem_d;
  // pres_q: a bit is on ser_dat_o with scan_clk low, its high phase comes next
  logic              pres_q, pres_d;
  logic              sclk_q, sclk_d;
  logic              dat_q, dat_d;

  assign word_rdy_o  = !full_q;
  assign word_done_o = sclk_q && (rem_q == NB_W'(1));
  assign ser_dat_o   = dat_q;
  assign scan_clk_o  = sclk_q;

  always_comb begin
    full_d = full_q;
    buf_d  = buf_q;
    rem_d  = rem_q;
    pres_d = pres_q;
    sclk_d = sclk_q;
    dat_d  = dat_q;
    if (sclk_q) begin
      // End of a high phase: either retire the word or present the next bit
      // straight away so a full buffer keeps the 2-cycle bit rhythm.
      sclk_d = 1'b0;
      if (rem_q == NB_W'(1)) begin
        full_d = 1'b0;
        pres_d = 1'b0;
        dat_d  = 1'b0;
      end else begin
        buf_d  = buf_q >> 1;
        rem_d  = rem_q - NB_W'(1);
        dat_d  = buf_q[1];
        pres_d = 1'b1;
      end
    end else if (pres_q) begin
      sclk_d = 1'b1;
      pres_d = 1'b0;
    end else if (full_q) begin
      dat_d  = buf_q[0];
      pres_d = 1'b1;
    end else if (word_vld_i) begin
      full_d = 1'b1;
      buf_d  = word_dat_i;
      rem_d  = word_nbits_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      buf_q  <= '0;
      rem_q  <= '0;
      pres_q <= 1'b0;
      sclk_q <= 1'b0;
      dat_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      buf_q  <= buf_d;
      rem_q  <= rem_d;
      pres_q <= pres_d;
      sclk_q <= sclk_d;
      dat_q  <= dat_d;
    end
  end

endmodule

// File: rtl/fabric_config_loader.sv
// Purpose: streams configuration words into the CLB scan chain, then the connection scan chain.
// Latency: 2 clk per chain bit plus 2 clk per word reload; enables drop 1 clk after a chain's last scan_clk rise.
// Backpressure: cfg_ready only while loading and the single word buffer is empty; scan_clk stalls low meanwhile.
// Optional feature: define CFG_CRC_EN to add a CRC-32 check word (CHECK state) and drive err.
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   start                         begin a load (honoured in IDLE/DONE only)
//   cfg_data/cfg_valid/cfg_ready  configuration word stream
//   scan_clk                      registered scan clock, idle low
//   clb_scan_en/clb_scan_data     CLB chain enable and serial data
//   conn_scan_en/conn_scan_data   connection chain enable and serial data
//   busy, done, err               status (err is CRC mismatch, 0 without CFG_CRC_EN)
module fabric_config_loader
  import fabric_cfg_pkg::*;
#(
  parameter int WORD_W         = CFG_WORD_W,
  parameter int CLB_CHAIN_LEN  = 4096,
  parameter int CONN_CHAIN_LEN = 8192,
  parameter int CNT_W          = $clog2((CLB_CHAIN_LEN > CONN_CHAIN_LEN) ?
                                        CLB_CHAIN_LEN : CONN_CHAIN_LEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_clk,
  output logic              clb_scan_en,
  output logic              conn_scan_en,
  output logic              clb_scan_data,
  output logic              conn_scan_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NB_W = $clog2(WORD_W + 1);

  cfg_state_e       state_q, state_d;
  // Bits of the current chain not yet handed to the serializer.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB_W-1:0]  nbits;
  logic             loading;
  logic             accept;
  logic             start_ok;
  logic             ser_rdy;
  logic             ser_vld;
  logic             ser_dat;
  logic             ser_sclk;
  logic             ser_word_done;

  assign loading   = (state_q == ST_LOAD_CLB) || (state_q == ST_LOAD_CONN);
  assign busy      = loading || (state_q == ST_CHECK);
  assign cfg_ready = ser_rdy && busy;
  assign accept    = cfg_valid && cfg_ready;
  assign ser_vld   = cfg_valid && loading;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // A chain's final word only contributes the bits the chain still needs;
  // its upper bits are dropped and the next chain starts on a fresh word.
  always_comb begin
    nbits = NB_W'(WORD_W);
    if (cnt_q < CNT_W'(WORD_W)) begin
      nbits = NB_W'(cnt_q);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept && loading) begin
      cnt_d = cnt_q - CNT_W'(nbits);
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD_CLB;
          cnt_d   = CNT_W'(CLB_CHAIN_LEN);
        end
      end
      // Word retired with nothing left to hand over = last bit of the chain.
      ST_LOAD_CLB: begin
        if (ser_word_done && (cnt_q == '0)) begin
          state_d = ST_LOAD_CONN;
          cnt_d   = CNT_W'(CONN_CHAIN_LEN);
        end
      end
      ST_LOAD_CONN: begin
        if (ser_word_done && (cnt_q == '0)) begin
`ifdef CFG_CRC_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
          cnt_d   = '0;
        end
      end
`ifdef CFG_CRC_EN
      ST_CHECK: begin
        if (accept) begin
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  cfg_serializer #(
    .WORD_W (WORD_W),
    .NB_W   (NB_W)
  ) u_ser (
    .clk          (clk),
    .rst          (rst),
    .word_dat_i   (cfg_data),
    .word_nbits_i (nbits),
    .word_vld_i   (ser_vld),
    .word_rdy_o   (ser_rdy),
    .ser_dat_o    (ser_dat),
    .scan_clk_o   (ser_sclk),
    .word_done_o  (ser_word_done)
  );

  assign scan_clk       = ser_sclk;
  assign clb_scan_en    = (state_q == ST_LOAD_CLB);
  assign conn_scan_en   = (state_q == ST_LOAD_CONN);
  assign clb_scan_data  = clb_scan_en && ser_dat;
  assign conn_scan_data = conn_scan_en && ser_dat;
  assign done           = (state_q == ST_DONE);

`ifdef CFG_CRC_EN
  logic [31:0] crc_q, crc_d, crc_word;
  logic        err_q, err_d;

  // Whole-word CRC update, MSB of the word first.
  always_comb begin
    crc_word = crc_q;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      crc_word = crc32_bit(crc_word, cfg_data[i]);
    end
  end

  always_comb begin
    crc_d = crc_q;
    err_d = err_q;
    if (start_ok) begin
      crc_d = CRC32_INIT;
      err_d = 1'b0;
    end else if (accept && loading) begin
      crc_d = crc_word;
    end else if (accept && (state_q == ST_CHECK)) begin
      err_d = (32'(cfg_data) != crc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC32_INIT;
      err_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_config_loader.sv
module tb_fabric_config_loader;

  localparam int WW         = 32;
  localparam int CLB        = 40;
  localparam int CONN       = 8;
  localparam int CLB_WORDS  = (CLB + WW - 1) / WW;
  localparam int CONN_WORDS = (CONN + WW - 1) / WW;
  localparam int NW         = CLB_WORDS + CONN_WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          scan_clk;
  logic          clb_scan_en;
  logic          conn_scan_en;
  logic          clb_scan_data;
  logic          conn_scan_data;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  fabric_config_loader #(
    .WORD_W         (WW),
    .CLB_CHAIN_LEN  (CLB),
    .CONN_CHAIN_LEN (CONN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .scan_clk       (scan_clk),
    .clb_scan_en    (clb_scan_en),
    .conn_scan_en   (conn_scan_en),
    .clb_scan_data  (clb_scan_data),
    .conn_scan_data (conn_scan_data),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  int            total = 0;
  int            bad   = 0;
  int            viol  = 0;
  bit            clb_q[$];
  bit            conn_q[$];
  logic [WW-1:0] words[NW];

  // Scan capture model: every clk cycle with scan_clk high is one rising edge
  // seen by the array; record the bit on whichever chain is enabled.
  always @(negedge clk) begin
    if (!rst) begin
      if (scan_clk) begin
        if (clb_scan_en && !conn_scan_en) clb_q.push_back(clb_scan_data);
        else if (conn_scan_en && !clb_scan_en) conn_q.push_back(conn_scan_data);
        else viol++;
      end
      if (!clb_scan_en && clb_scan_data) viol++;
      if (!conn_scan_en && conn_scan_data) viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the buffer to empty, hold the word back for 'gap' cycles while
  // checking the stall behaviour, then present it for one handshake.
  task automatic send_word(input logic [WW-1:0] w, input int gap,
                           input logic exp_clb, input logic exp_conn);
    int t;
    bit ok;
    t = 0;
    while (!cfg_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", (t >= 1000), 0);
    ok = 1'b1;
    for (int i = 0; i < gap; i++) begin
      if (scan_clk !== 1'b0 || clb_scan_en !== exp_clb || conn_scan_en !== exp_conn) ok = 1'b0;
      @(negedge clk);
    end
    if (gap > 0) chk("stall_hold", ok, 1);
    cfg_data  = w;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_data  = '0;
  endtask

`ifdef CFG_CRC_EN
  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < NW; k++)
      for (int b = WW - 1; b >= 0; b--)
        c = (c[31] ^ words[k][b]) ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    return c;
  endfunction
`endif

  // gap < 0 selects random gaps per word.
  task automatic run_load(input int gap, input bit mid_start, input bit crc_flip);
    logic [CLB-1:0]  exp_clb, act_clb;
    logic [CONN-1:0] exp_conn, act_conn;
    int              t;
    int              g;
    logic [31:0]     flip;
    clb_q.delete();
    conn_q.delete();
    viol = 0;
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
`ifdef CFG_CRC_EN
    chk("err_after_start", err, 0);
`endif
    for (int k = 0; k < NW; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 6)) : gap;
      send_word(words[k], g, (k < CLB_WORDS), (k >= CLB_WORDS));
      if (mid_start && k == NW - 1) begin
        pulse_start();
        chk("mid_start_busy", busy, 1);
      end
    end
`ifdef CFG_CRC_EN
    flip = crc_flip ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
    send_word(model_crc() ^ flip, 0, 1'b0, 1'b0);
`else
    flip = 32'h0;
`endif
    t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", (t >= 2000), 0);
    for (int i = 0; i < CLB; i++) exp_clb[i] = words[i / WW][i % WW];
    for (int i = 0; i < CONN; i++) exp_conn[i] = words[CLB_WORDS + i / WW][i % WW];
    act_clb  = '0;
    act_conn = '0;
    for (int i = 0; i < CLB && i < clb_q.size(); i++) act_clb[i] = clb_q[i];
    for (int i = 0; i < CONN && i < conn_q.size(); i++) act_conn[i] = conn_q[i];
    chk("clb_pulses", clb_q.size(), CLB);
    chk("conn_pulses", conn_q.size(), CONN);
    chk("clb_bits", act_clb, exp_clb);
    chk("conn_bits", act_conn, exp_conn);
    chk("scan_violations", viol, 0);
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    chk("ready_end", cfg_ready, 0);
`ifdef CFG_CRC_EN
    chk("err_end", err, (flip != 0));
`endif
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {scan_clk, clb_scan_en, conn_scan_en, clb_scan_data,
                          conn_scan_data, busy, done, err, cfg_ready}, 9'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {scan_clk, clb_scan_en, conn_scan_en, busy, done, cfg_ready}, 6'h0);

    // Directed load, words back to back.
    words[0] = 32'h000000A5;
    words[1] = 32'h00000003;
    words[2] = 32'h0000003C;
    run_load(0, 1'b0, 1'b0);

    // Same load with 10-cycle stalls between words.
    run_load(10, 1'b0, 1'b0);

    // Reset after the 20th CLB pulse.
    clb_q.delete();
    conn_q.delete();
    pulse_start();
    send_word(words[0], 0, 1'b1, 1'b0);
    begin
      int t;
      t = 0;
      while (clb_q.size() < 20 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      chk("pulse20_timeout", (t >= 1000), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midload_reset", {scan_clk, clb_scan_en, conn_scan_en, clb_scan_data,
                          conn_scan_data, busy, done, err, cfg_ready}, 9'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {busy, done, cfg_ready, scan_clk}, 4'h0);
    run_load(0, 1'b0, 1'b0);

    // start during LOAD_CONN is ignored; the next run's start comes from DONE.
    run_load(0, 1'b1, 1'b0);

    // Randomised loads; one of them corrupts the CRC word when CRC is built in.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < NW; k++) words[k] = $urandom;
      run_load(-1, (r == 3), (r == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
